// File: rtl/dp_ram_slave.sv
// Dual-port 32-bit RAM slave: single-cycle byte-enabled writes, reads with
// RD_WAIT wait states, and bytewise write-first forwarding on collisions.

module dp_ram_lane #(
  parameter int ADDR_WIDTH = 12,
  parameter int LANE_W     = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [LANE_W-1:0]     wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [LANE_W-1:0]     rdata
);
  logic [LANE_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Write-first: a same-cycle write to this lane wins over the stored byte.
  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];
endmodule

module dp_ram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_WAIT    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [3:0]  rd_be,
  input  logic [31:0] rd_addr,
  output logic        rd_gnt,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_conflict,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_gnt
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  generate
    if (RD_WAIT < 0 || RD_WAIT > 7) begin : g_bad_rd_wait
      $error("dp_ram_slave: RD_WAIT must be in 0..7");
    end
  endgenerate

  localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]                rd_idx, wr_idx;
  logic [NUM_LANES-1:0][LANE_W-1:0]     fwd_word, fwd_masked, snap;
  logic [2:0]                           cnt;
  logic                                 hit, conf_q;

  assign rd_idx = rd_addr[ADDR_WIDTH+1:2];
  assign wr_idx = wr_addr[ADDR_WIDTH+1:2];
  assign wr_gnt = wr_req;
  assign hit    = wr_req && (wr_idx == rd_idx) && ((rd_be & wr_be) != 4'b0);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:ADDR_WIDTH+2], rd_addr[1:0],
                              wr_addr[31:ADDR_WIDTH+2], wr_addr[1:0]};

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      dp_ram_lane #(.ADDR_WIDTH(ADDR_WIDTH), .LANE_W(LANE_W)) u_lane (
        .clk   (clk),
        .we    (wr_req && wr_be[i]),
        .waddr (wr_idx),
        .wdata (wr_data[i*LANE_W +: LANE_W]),
        .raddr (rd_idx),
        .rdata (fwd_word[i])
      );
      assign fwd_masked[i] = rd_be[i] ? fwd_word[i] : '0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, RESP: if (rd_req) state_nxt = (RD_WAIT == 0) ? RESP : WAIT;
      WAIT:       state_nxt = (cnt == 3'd1) ? RESP : WAIT;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    rd_gnt   = 1'b0;
    rd_valid = 1'b0;
    case (state)
      IDLE:    rd_gnt = rd_req;
      RESP: begin
        rd_gnt   = rd_req;
        rd_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Snapshot is taken already masked at accept so later writes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      snap        <= '0;
      conf_q      <= 1'b0;
      rd_data     <= '0;
      rd_conflict <= 1'b0;
    end else begin
      if (state == WAIT) cnt <= cnt - 3'd1;
      if (rd_gnt) begin
        cnt    <= WAIT_INIT;
        snap   <= fwd_masked;
        conf_q <= hit;
      end
      if (state_nxt == RESP) begin
        rd_data     <= rd_gnt ? fwd_masked : snap;
        rd_conflict <= rd_gnt ? hit : conf_q;
      end else begin
        rd_conflict <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dp_ram_slave.sv
// Randomized self-checking bench for dp_ram_slave; a word-array model predicts
// read data, conflicts and latency for RD_WAIT=0 and RD_WAIT=2 instances.

module tb_dp_ram_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req;
  logic [3:0]  rd_be, wr_be;
  logic [31:0] rd_addr, wr_addr, wr_data;

  logic        rd_gnt0, rd_valid0, rd_conf0, wr_gnt0;
  logic [31:0] rd_data0;
  logic        rd_gnt2, rd_valid2, rd_conf2, wr_gnt2;
  logic [31:0] rd_data2;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;  // 0: check RD_WAIT=0 instance, 1: RD_WAIT=2 instance

  logic [31:0] model [4096];

  always #5 clk = ~clk;

  dp_ram_slave #(.ADDR_WIDTH(12), .RD_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_be(rd_be), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt0), .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_conflict(rd_conf0),
    .wr_req(wr_req), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt0)
  );

  dp_ram_slave #(.ADDR_WIDTH(12), .RD_WAIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_be(rd_be), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt2), .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_conflict(rd_conf2),
    .wr_req(wr_req), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt2)
  );

  logic        s_gnt, s_valid, s_conf, s_wgnt;
  logic [31:0] s_data;
  assign s_gnt   = sel ? rd_gnt2   : rd_gnt0;
  assign s_valid = sel ? rd_valid2 : rd_valid0;
  assign s_conf  = sel ? rd_conf2  : rd_conf0;
  assign s_wgnt  = sel ? wr_gnt2   : wr_gnt0;
  assign s_data  = sel ? rd_data2  : rd_data0;

  function automatic int idx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic logic [31:0] mask(input logic [31:0] w, input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? w[b*8 +: 8] : 8'h00;
    return m;
  endfunction

  function automatic void mdl_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) model[idx(a)][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_req = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    @(posedge clk);
    mdl_write(a, be, d);
    #1 wr_req = 1'b0;
  endtask

  task automatic rd_txn(input string nm, input logic [31:0] a, input logic [3:0] be,
                        input bit cw, input logic [31:0] wa, input logic [3:0] wbe,
                        input logic [31:0] wd);
    int lat;
    int want_lat;
    logic [31:0] exp;
    bit expc;
    want_lat = sel ? 2 : 0;
    rd_req = 1'b1; rd_addr = a; rd_be = be;
    wr_req = cw; wr_addr = wa; wr_be = wbe; wr_data = wd;
    #1;
    checks++;
    if (s_gnt !== 1'b1) begin errors++; $display("FAIL %s rd_gnt: got %b want 1", nm, s_gnt); end
    checks++;
    if (s_wgnt !== cw) begin errors++; $display("FAIL %s wr_gnt: got %b want %b", nm, s_wgnt, cw); end
    @(posedge clk);
    if (cw) mdl_write(wa, wbe, wd);
    exp  = mask(model[idx(a)], be);
    expc = cw && (idx(wa) == idx(a)) && ((be & wbe) != 4'b0);
    #1 rd_req = 1'b0; wr_req = 1'b0;
    lat = 0;
    while (s_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != want_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, want_lat); end
    checks++;
    if (s_data !== exp) begin errors++; $display("FAIL %s rd_data: got %h want %h", nm, s_data, exp); end
    checks++;
    if (s_conf !== expc) begin errors++; $display("FAIL %s rd_conflict: got %b want %b", nm, s_conf, expc); end
    @(posedge clk); #1;
    checks++;
    if (s_valid !== 1'b0 || s_conf !== 1'b0 || s_data !== exp)
      begin errors++; $display("FAIL %s after pulse: valid %b conf %b data %h want 0 0 %h", nm, s_valid, s_conf, s_data, exp); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_be = 4'h0; wr_be = 4'h0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    #1;
    checks++;
    if ({rd_valid0, rd_conf0, rd_gnt0, wr_gnt0, rd_valid2, rd_conf2, rd_gnt2, wr_gnt2} !== 8'h00
        || rd_data0 !== 32'h0 || rd_data2 !== 32'h0)
      begin errors++; $display("FAIL reset_outputs: got d0=%h d2=%h v0=%b v2=%b want zeros", rd_data0, rd_data2, rd_valid0, rd_valid2); end
    rd_req = 1'b1; wr_req = 1'b1; #1;
    checks++;
    if ({rd_gnt0, wr_gnt0, rd_gnt2, wr_gnt2} !== 4'hF)
      begin errors++; $display("FAIL reset_grants: got %b want 1111", {rd_gnt0, wr_gnt0, rd_gnt2, wr_gnt2}); end
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4096; i++) wr({18'h0, i[11:0], 2'b00}, 4'hF, $urandom);
  endtask

  task automatic test_basic;
    sel = 1'b0;
    wr(32'h10, 4'hF, 32'hDEADBEEF);
    rd_txn("basic", 32'h10, 4'hF, 1'b0, '0, '0, '0);
  endtask

  task automatic test_byte_write;
    sel = 1'b0;
    wr(32'h20, 4'hF, 32'h11223344);
    wr(32'h20, 4'b0100, 32'h00AA0000);
    rd_txn("byte_full", 32'h20, 4'hF, 1'b0, '0, '0, '0);
    rd_txn("byte_half", 32'h20, 4'b0011, 1'b0, '0, '0, '0);
    wr(32'h20, 4'h0, 32'hFFFFFFFF);
    rd_txn("be_zero_noop", 32'h20, 4'hF, 1'b0, '0, '0, '0);
  endtask

  task automatic test_collision;
    sel = 1'b0;
    wr(32'h30, 4'hF, 32'h12345678);
    rd_txn("collision", 32'h30, 4'hF, 1'b1, 32'h30, 4'b1100, 32'hCAFEF00D);
    sel = 1'b1;
    wr(32'h34, 4'hF, 32'h12345678);
    rd_txn("collision_w2", 32'h34, 4'b0011, 1'b1, 32'h34, 4'b0110, 32'hCAFEF00D);
    rd_txn("no_overlap", 32'h34, 4'b0001, 1'b1, 32'h34, 4'b1000, 32'hAB000000);
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] exp;
    sel = 1'b0;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    for (int k = 0; k < 3; k++) wr(addrs[k], 4'hF, $urandom);
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1; rd_addr = addrs[k]; rd_be = 4'hF;
      #1;
      checks++;
      if (rd_gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d: got %b want 1", k, rd_gnt0); end
      @(posedge clk); #1;
      exp = model[idx(addrs[k])];
      checks++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== exp)
        begin errors++; $display("FAIL b2b_data%0d: valid %b data %h want 1 %h", k, rd_valid0, rd_data0, exp); end
    end
    rd_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_end: valid %b want 0", rd_valid0); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_wait_states;
    logic [31:0] exp;
    sel = 1'b1;
    wr(32'h40, 4'hF, 32'hA5A5A5A5);
    exp = model[idx(32'h40)];
    rd_req = 1'b1; rd_addr = 32'h40; rd_be = 4'hF;
    #1;
    checks++;
    if (rd_gnt2 !== 1'b1) begin errors++; $display("FAIL wait_accept: gnt %b want 1", rd_gnt2); end
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 32'h40; wr_be = 4'hF; wr_data = 32'h5A5A5A5A;
    #1;
    checks++;
    if (rd_gnt2 !== 1'b0 || rd_valid2 !== 1'b0)
      begin errors++; $display("FAIL wait_c1: gnt %b valid %b want 0 0", rd_gnt2, rd_valid2); end
    @(posedge clk);
    mdl_write(32'h40, 4'hF, 32'h5A5A5A5A);
    #1 wr_req = 1'b0;
    checks++;
    if (rd_gnt2 !== 1'b0 || rd_valid2 !== 1'b0)
      begin errors++; $display("FAIL wait_c2: gnt %b valid %b want 0 0", rd_gnt2, rd_valid2); end
    @(posedge clk); #1;
    checks++;
    if (rd_valid2 !== 1'b1 || rd_data2 !== exp || rd_conf2 !== 1'b0)
      begin errors++; $display("FAIL wait_c3: valid %b data %h conf %b want 1 %h 0", rd_valid2, rd_data2, rd_conf2, exp); end
    rd_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_valid2 !== 1'b0 || rd_data2 !== exp)
      begin errors++; $display("FAIL wait_hold: valid %b data %h want 0 %h", rd_valid2, rd_data2, exp); end
    repeat (3) @(posedge clk);
    #1;
    rd_txn("wait_after_write", 32'h40, 4'hF, 1'b0, '0, '0, '0);
  endtask

  task automatic test_random;
    logic [31:0] a, wa, wd;
    logic [3:0]  be, wbe;
    int op;
    for (int n = 0; n < 200; n++) begin
      sel = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 2);
      a   = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'h0, 8'h0, 4'($urandom), 2'($urandom)};
      wa  = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'h0, 8'h0, 4'($urandom_range(0, 3)), 2'($urandom)};
      if (op == 2) wa[5:2] = a[5:2];
      be  = 4'($urandom);
      wbe = 4'($urandom);
      wd  = $urandom;
      if (op == 0) wr(wa, wbe, wd);
      else         rd_txn("random", a, be, op == 2, wa, wbe, wd);
    end
  endtask

  task automatic test_reset_mid_read;
    bit seen;
    sel = 1'b1;
    wr(32'h50, 4'hF, 32'hDEADBEEF);
    rd_txn("pre_reset", 32'h50, 4'hF, 1'b0, '0, '0, '0);
    rd_req = 1'b1; rd_addr = 32'h54; rd_be = 4'hF;
    @(posedge clk); #1;
    rd_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid2 !== 1'b0 || rd_conf2 !== 1'b0 || rd_data2 !== 32'h0 || rd_data0 !== 32'h0)
      begin errors++; $display("FAIL reset_mid_read: valid %b conf %b data2 %h data0 %h want 0", rd_valid2, rd_conf2, rd_data2, rd_data0); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (rd_valid2 !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_drop: got rd_valid after reset, want none"); end
  endtask

  task automatic test_alias;
    sel = 1'b0;
    wr(32'h4000, 4'hF, 32'h600DF00D);
    rd_txn("alias", 32'h0, 4'hF, 1'b0, '0, '0, '0);
    sel = 1'b1;
    wr(32'hFFFF_C008, 4'hF, $urandom);
    rd_txn("alias_w2", 32'h8, 4'hF, 1'b0, '0, '0, '0);
  endtask

  initial begin
    test_reset;
    test_fill;
    test_basic;
    test_byte_write;
    test_collision;
    test_back_to_back;
    test_wait_states;
    test_random;
    test_reset_mid_read;
    test_alias;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dp_ram_slave.md
# dp_ram_slave

Single-clock, dual-port 32-bit RAM that sits on the slave (responder) side of the `dualport_bus` interface, answering the pipeline memory stage's read and write requests. It performs byte-enabled writes in one cycle and returns read data after one cycle plus a programmable number of wait states, with an `rd_gnt`/`rd_valid` handshake. It resolves same-cycle read/write collisions to the same word by bytewise write-first forwarding, and flags each collision to the master.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- `RD_WAIT`, default 0: extra read wait cycles, legal range 0..7.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `rd_req`  in  1  read request.
- `rd_be`  in  4  read byte enables.
- `rd_addr`  in  32  byte address of the read.
- `rd_gnt`  out  1  read accepted this cycle (combinational).
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid in this cycle.
- `rd_data`  out  32  read data, held between pulses.
- `rd_conflict`  out  1  pulses with `rd_valid` when the read collided with a write.
- `wr_req`  in  1  write request.
- `wr_be`  in  4  write byte enables.
- `wr_addr`  in  32  byte address of the write.
- `wr_data`  in  32  write data, already lane-aligned.
- `wr_gnt`  out  1  write accepted; equals `wr_req` (combinational).

## Operation
- **Addressing**
  - Word index = `addr[ADDR_WIDTH+1:2]`.
  - `addr[1:0]` and bits above `ADDR_WIDTH+1` are ignored, so upper addresses alias.
- **Write**
  - On a posedge with `wr_req`=1, byte lane i of the word at `wr_addr` is written if and only if `wr_be[i]`=1. The other lanes are unchanged.
  - `wr_be`=0 is a legal no-op and still gets a grant.
  - Writes are never stalled.
- **Read state machine**, states IDLE, WAIT, RESP:
  - IDLE: `rd_gnt`=`rd_req`.
    - On accept, snapshot the addressed word, merging any same-cycle write bytewise (write-first).
    - Latch `rd_be`.
    - Load the 3-bit counter with `RD_WAIT`.
    - Next state is RESP if `RD_WAIT`=0, otherwise WAIT.
  - WAIT: `rd_gnt`=0. The counter decrements each cycle. When it reaches 1, go to RESP.
  - RESP:
    - `rd_valid`=1.
    - `rd_data` = snapshot with lanes where latched `rd_be`=0 forced to 0x00.
    - `rd_gnt`=`rd_req`. An accept here behaves as in IDLE (back-to-back reads); otherwise go to IDLE.
- **Collision**
  - Defined as: a read is accepted in the same cycle as a write to the same word index, with `rd_be & wr_be` ≠ 0.
  - Data returned for overlapping lanes is the new write data.
  - `rd_conflict`=1 in that read's RESP cycle, 0 in all other cycles.
- **Isolation**: writes issued after the accept cycle do not change an in-flight read's data.
- **Memory contents**: not reset and undefined until written. The bench writes every location before reading it.

## Timing
- **Reset values**: `rd_valid`=0, `rd_conflict`=0, `rd_data`=0, state IDLE, counter 0. The grants follow their combinational definitions.
- **Read latency**: `rd_valid` rises 1+`RD_WAIT` cycles after the accept edge.
- **Read throughput**: 1 read per cycle when `RD_WAIT`=0; one per (1+`RD_WAIT`) cycles otherwise.
- **Write latency**: data is visible to a read accepted in the cycle after the write edge, and in the write cycle itself via forwarding.
- **Master handshake**: the master holds `rd_req`, `rd_addr` and `rd_be` stable until `rd_gnt`=1.
- **Reset mid-read**: the pending read is dropped, no `rd_valid` is produced, and the state returns to IDLE asynchronously.
- **Illegal parameter**: `RD_WAIT`>7 is an elaboration error.

## Test plan
- **Basic write/read**: write `0xDEADBEEF` to 0x10 with be=F, then read 0x10 with be=F → `rd_valid` 1 cycle after grant, `rd_data`=`0xDEADBEEF`, `rd_conflict`=0.
- **Byte and half writes**: on word 0x20 preloaded with `0x11223344`, write be=0100 data `0x00AA0000`, then read with be=F → `0x11AA3344`. Then read with be=0011 → `0x00003344`.
- **Collision**: same cycle, write `0xCAFEF00D` be=1100 and read be=F, both to 0x30 holding `0x12345678` → `rd_data`=`0xCAFE5678`, `rd_conflict`=1.
- **Back-to-back reads** (`RD_WAIT`=0): three consecutive reads of 0x0, 0x4, 0x8 → `rd_gnt` high for 3 cycles, `rd_valid` high for 3 consecutive cycles with the data in order.
- **Wait states** (`RD_WAIT`=2): a read held with `rd_req`=1 → `rd_gnt` is low for 2 cycles after the accept and `rd_valid` comes at accept+3. A write to the same word during the wait does not alter the returned data.
- **Reset mid-read and aliasing**:
  - Assert `rst_n`=0 during WAIT → no `rd_valid`, outputs return to 0.
  - After reset, with `ADDR_WIDTH`=12, write 0x4000 and read 0x0 → the read returns the same word.
